// File: rtl/ttc_irq_pkg4.sv
// Shared register offsets, CFG field layout and FSM encoding for the TTC interrupt coalescer.
// The coalescing engine is only built when TTC_IRQ_COALESCE_EN is defined.
package ttc_irq_pkg4;

    localparam int unsigned NUM_INT = 3;

    localparam logic [7:0] REG_RAW   = 8'h00;
    localparam logic [7:0] REG_STAT  = 8'h04;
    localparam logic [7:0] REG_MASK  = 8'h08;
    localparam logic [7:0] REG_PEND  = 8'h0C;
    localparam logic [7:0] REG_CFG   = 8'h10;
    localparam logic [7:0] REG_CNT   = 8'h14;
    localparam logic [7:0] REG_STATE = 8'h18;

    localparam int unsigned CFG_THR_LSB = 0;
    localparam int unsigned CFG_TMO_LSB = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_ASSERT  = 2'd2
    } state_t;

    // Number of timer interrupts that fired together in one cycle.
    function automatic logic [1:0] popcnt3(input logic [2:0] v);
        return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
    endfunction

endpackage

// File: rtl/ttc_irq_edge4.sv
// Per-bit rising-edge detector with sticky write-one-to-clear status.
// A new edge and a clear hitting the same bit in one cycle leave the bit set.
module ttc_irq_edge4 #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    input  logic [W-1:0] w1c,
    output logic [W-1:0] prev,
    output logic [W-1:0] stat,
    output logic [W-1:0] new_c
);

    assign new_c = din & ~prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= '0;
            stat <= '0;
        end else begin
            prev <= din;
            stat <= (stat & ~w1c) | new_c;
        end
    end

endmodule

// File: rtl/ttc_irq_coal4.sv
// APB4 interrupt collector for TTC interrupt[3:1]: sticky status, mask, and a
// count/holdoff coalescing FSM enabled by TTC_IRQ_COALESCE_EN (else irq follows PEND).
module ttc_irq_coal4
    import ttc_irq_pkg4::*;
#(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned TMR_W = 16
) (
    input  logic        pclk4,
    input  logic        n_p_reset4,
    input  logic        psel4,
    input  logic        penable4,
    input  logic        pwrite4,
    input  logic [7:0]  paddr4,
    input  logic [31:0] pwdata4,
    input  logic [2:0]  ttc_int4,
    output logic [31:0] prdata4,
    output logic        irq_out4
);

    logic               wr_c;
    logic               rd_c;
    logic [NUM_INT-1:0] raw;
    logic [NUM_INT-1:0] stat;
    logic [NUM_INT-1:0] new_c;
    logic [NUM_INT-1:0] w1c_c;
    logic [NUM_INT-1:0] mask;
    logic [NUM_INT-1:0] pend;
    logic               unused_ok;

    assign wr_c      = psel4 & penable4 & pwrite4;
    assign rd_c      = psel4 & ~pwrite4;
    assign w1c_c     = (wr_c && paddr4 == REG_STAT) ? pwdata4[NUM_INT-1:0] : '0;
    assign pend      = stat & mask;
    assign unused_ok = ^{pwdata4[31:NUM_INT], new_c};

    ttc_irq_edge4 #(.W(NUM_INT)) u_edge (
        .clk   (pclk4),
        .rst_n (n_p_reset4),
        .din   (ttc_int4),
        .w1c   (w1c_c),
        .prev  (raw),
        .stat  (stat),
        .new_c (new_c)
    );

    always_ff @(posedge pclk4 or negedge n_p_reset4) begin
        if (!n_p_reset4) begin
            mask <= '0;
        end else if (wr_c && paddr4 == REG_MASK) begin
            mask <= pwdata4[NUM_INT-1:0];
        end
    end

`ifdef TTC_IRQ_COALESCE_EN
    state_t             state;
    logic [CNT_W-1:0]   thr;
    logic [CNT_W-1:0]   cnt;
    logic [TMR_W-1:0]   tmo;
    logic [TMR_W-1:0]   tmr;
    logic [NUM_INT-1:0] evt_q;
    logic [CNT_W-1:0]   thr_eff_c;
    logic [CNT_W:0]     cnt_sum_c;
    logic [CNT_W-1:0]   cnt_sat_c;

    assign thr_eff_c = (thr == '0) ? CNT_W'(1) : thr;
    assign cnt_sum_c = {1'b0, cnt} + (CNT_W+1)'(popcnt3(evt_q));
    assign cnt_sat_c = cnt_sum_c[CNT_W] ? '1 : cnt_sum_c[CNT_W-1:0];

    // Masked edges are staged one cycle so the FSM reacts the cycle after STAT sets.
    always_ff @(posedge pclk4 or negedge n_p_reset4) begin
        if (!n_p_reset4) begin
            state    <= ST_IDLE;
            thr      <= CNT_W'(1);
            tmo      <= '0;
            cnt      <= '0;
            tmr      <= '0;
            evt_q    <= '0;
            irq_out4 <= 1'b0;
        end else begin
            if (wr_c && paddr4 == REG_CFG) begin
                thr <= pwdata4[CFG_THR_LSB +: CNT_W];
                tmo <= pwdata4[CFG_TMO_LSB +: TMR_W];
            end
            evt_q    <= new_c & mask;
            cnt      <= cnt_sat_c;
            irq_out4 <= (state == ST_ASSERT);
            case (state)
                ST_IDLE: begin
                    if (|evt_q) begin
                        if (cnt_sat_c >= thr_eff_c) begin
                            state <= ST_ASSERT;
                        end else begin
                            state <= ST_COLLECT;
                            tmr   <= tmo;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (cnt >= thr_eff_c || (tmo != '0 && tmr == TMR_W'(1))) begin
                        state <= ST_ASSERT;
                        tmr   <= '0;
                    end else if (tmo != '0 && tmr != '0) begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                ST_ASSERT: begin
                    if (pend == '0) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
`else
    logic [CNT_W+TMR_W-1:0] unused_cfg;
    assign unused_cfg = '0;

    always_ff @(posedge pclk4 or negedge n_p_reset4) begin
        if (!n_p_reset4) begin
            irq_out4 <= 1'b0;
        end else begin
            irq_out4 <= |pend;
        end
    end
`endif

    // Zero-wait-state read mux; unmapped or disabled registers read as zero.
    always_comb begin
        prdata4 = '0;
        if (rd_c) begin
            case (paddr4)
                REG_RAW:   prdata4[NUM_INT-1:0] = raw;
                REG_STAT:  prdata4[NUM_INT-1:0] = stat;
                REG_MASK:  prdata4[NUM_INT-1:0] = mask;
                REG_PEND:  prdata4[NUM_INT-1:0] = pend;
`ifdef TTC_IRQ_COALESCE_EN
                REG_CFG: begin
                    prdata4[CFG_THR_LSB +: CNT_W] = thr;
                    prdata4[CFG_TMO_LSB +: TMR_W] = tmo;
                end
                REG_CNT:   prdata4[CNT_W-1:0] = cnt;
                REG_STATE: prdata4[1:0] = state;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ttc_irq_coal4.sv
// Directed self-checking bench for ttc_irq_coal4; expectations follow the
// TTC_IRQ_COALESCE_EN setting of the build.
module tb_ttc_irq_coal4;

`ifdef TTC_IRQ_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif

    logic        pclk4 = 1'b0;
    logic        n_p_reset4;
    logic        psel4;
    logic        penable4;
    logic        pwrite4;
    logic [7:0]  paddr4;
    logic [31:0] pwdata4;
    logic [2:0]  ttc_int4;
    logic [31:0] prdata4;
    logic        irq_out4;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] rd;

    always #5 pclk4 = ~pclk4;

    ttc_irq_coal4 dut (
        .pclk4      (pclk4),
        .n_p_reset4 (n_p_reset4),
        .psel4      (psel4),
        .penable4   (penable4),
        .pwrite4    (pwrite4),
        .paddr4     (paddr4),
        .pwdata4    (pwdata4),
        .ttc_int4   (ttc_int4),
        .prdata4    (prdata4),
        .irq_out4   (irq_out4)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge pclk4);
            #1;
        end
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        psel4 = 1'b1; pwrite4 = 1'b1; penable4 = 1'b0; paddr4 = a; pwdata4 = d;
        tick();
        penable4 = 1'b1;
        tick();
        psel4 = 1'b0; penable4 = 1'b0; pwrite4 = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
        psel4 = 1'b1; pwrite4 = 1'b0; penable4 = 1'b0; paddr4 = a;
        #1;
        d = prdata4;
        psel4 = 1'b0;
    endtask

    task automatic pulse(input logic [2:0] b);
        ttc_int4 = b;
        tick();
        ttc_int4 = 3'b000;
    endtask

    task automatic test_reset;
        logic [7:0]  addrs [7];
        logic [31:0] exp;
        addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18};
        n_p_reset4 = 1'b0; psel4 = 1'b0; penable4 = 1'b0; pwrite4 = 1'b0;
        paddr4 = 8'h00; pwdata4 = 32'h0; ttc_int4 = 3'b000;
        tick(3);
        n_cmp++; if (irq_out4 !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b expected 0", irq_out4); end
        n_p_reset4 = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) begin
            exp = (i == 4) ? 32'(COAL) : 32'h0;
            apb_read(addrs[i], rd);
            n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL reset_reg_%02h: got %h expected %h", addrs[i], rd, exp); end
        end
    endtask

    task automatic test_basic;
        apb_write(8'h08, 32'h7);
        apb_write(8'h10, 32'h1);
        pulse(3'b010);
        apb_read(8'h04, rd);
        n_cmp++; if (rd !== 32'h2) begin n_err++; $display("FAIL basic_stat: got %h expected %h", rd, 32'h2); end
        n_cmp++; if (irq_out4 !== 1'b0) begin n_err++; $display("FAIL basic_irq_e0: got %b expected 0", irq_out4); end
        tick();
        n_cmp++; if (irq_out4 !== !COAL) begin n_err++; $display("FAIL basic_irq_e1: got %b expected %b", irq_out4, !COAL); end
        tick();
        n_cmp++; if (irq_out4 !== 1'b1) begin n_err++; $display("FAIL basic_irq_e2: got %b expected 1", irq_out4); end
        apb_read(8'h18, rd);
        n_cmp++; if (rd !== (COAL ? 32'h2 : 32'h0)) begin n_err++; $display("FAIL basic_state: got %h expected %h", rd, COAL ? 32'h2 : 32'h0); end
        apb_write(8'h04, 32'h2);
        n_cmp++; if (irq_out4 !== 1'b1) begin n_err++; $display("FAIL basic_clr_x0: got %b expected 1", irq_out4); end
        tick();
        n_cmp++; if (irq_out4 !== COAL) begin n_err++; $display("FAIL basic_clr_x1: got %b expected %b", irq_out4, COAL); end
        tick();
        n_cmp++; if (irq_out4 !== 1'b0) begin n_err++; $display("FAIL basic_clr_x2: got %b expected 0", irq_out4); end
        apb_read(8'h14, rd);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL basic_cnt: got %h expected 0", rd); end
    endtask

    task automatic test_threshold;
        apb_write(8'h10, 32'h3);
        pulse(3'b001);
        tick(3);
        n_cmp++; if (irq_out4 !== !COAL) begin n_err++; $display("FAIL thr_irq_p1: got %b expected %b", irq_out4, !COAL); end
        pulse(3'b001);
        tick(3);
        n_cmp++; if (irq_out4 !== !COAL) begin n_err++; $display("FAIL thr_irq_p2: got %b expected %b", irq_out4, !COAL); end
        apb_read(8'h18, rd);
        n_cmp++; if (rd !== 32'(COAL)) begin n_err++; $display("FAIL thr_state_p2: got %h expected %h", rd, 32'(COAL)); end
        apb_read(8'h14, rd);
        n_cmp++; if (rd !== (COAL ? 32'h2 : 32'h0)) begin n_err++; $display("FAIL thr_cnt_p2: got %h expected %h", rd, COAL ? 32'h2 : 32'h0); end
        pulse(3'b001);
        tick(3);
        n_cmp++; if (irq_out4 !== 1'b1) begin n_err++; $display("FAIL thr_irq_p3: got %b expected 1", irq_out4); end
        apb_read(8'h14, rd);
        n_cmp++; if (rd !== (COAL ? 32'h3 : 32'h0)) begin n_err++; $display("FAIL thr_cnt_p3: got %h expected %h", rd, COAL ? 32'h3 : 32'h0); end
        apb_write(8'h04, 32'h7);
        tick(3);
        n_cmp++; if (irq_out4 !== 1'b0) begin n_err++; $display("FAIL thr_irq_clr: got %b expected 0", irq_out4); end
    endtask

    task automatic test_timeout;
        apb_write(8'h10, 32'h0000_0A08);
        apb_read(8'h10, rd);
        n_cmp++; if (rd !== (COAL ? 32'h0000_0A08 : 32'h0)) begin n_err++; $display("FAIL tmo_cfg: got %h expected %h", rd, COAL ? 32'h0000_0A08 : 32'h0); end
        pulse(3'b100);
        tick();
        apb_read(8'h18, rd);
        n_cmp++; if (rd !== 32'(COAL)) begin n_err++; $display("FAIL tmo_state: got %h expected %h", rd, 32'(COAL)); end
        apb_read(8'h14, rd);
        n_cmp++; if (rd !== 32'(COAL)) begin n_err++; $display("FAIL tmo_cnt: got %h expected %h", rd, 32'(COAL)); end
        tick(10);
        n_cmp++; if (irq_out4 !== !COAL) begin n_err++; $display("FAIL tmo_irq_e11: got %b expected %b", irq_out4, !COAL); end
        tick();
        n_cmp++; if (irq_out4 !== 1'b1) begin n_err++; $display("FAIL tmo_irq_e12: got %b expected 1", irq_out4); end
        apb_write(8'h04, 32'h7);
        tick(3);
        n_cmp++; if (irq_out4 !== 1'b0) begin n_err++; $display("FAIL tmo_irq_clr: got %b expected 0", irq_out4); end
    endtask

    task automatic test_thr_zero_popcount;
        apb_write(8'h10, 32'h0);
        pulse(3'b001);
        tick(2);
        n_cmp++; if (irq_out4 !== 1'b1) begin n_err++; $display("FAIL thr0_irq: got %b expected 1", irq_out4); end
        apb_write(8'h04, 32'h7);
        tick(3);
        apb_write(8'h10, 32'h3);
        pulse(3'b111);
        tick();
        apb_read(8'h14, rd);
        n_cmp++; if (rd !== (COAL ? 32'h3 : 32'h0)) begin n_err++; $display("FAIL pop_cnt: got %h expected %h", rd, COAL ? 32'h3 : 32'h0); end
        apb_read(8'h18, rd);
        n_cmp++; if (rd !== (COAL ? 32'h2 : 32'h0)) begin n_err++; $display("FAIL pop_state: got %h expected %h", rd, COAL ? 32'h2 : 32'h0); end
        tick();
        n_cmp++; if (irq_out4 !== 1'b1) begin n_err++; $display("FAIL pop_irq: got %b expected 1", irq_out4); end
        apb_write(8'h04, 32'h7);
        tick(3);
    endtask

    task automatic test_set_wins;
        apb_write(8'h10, 32'h1);
        psel4 = 1'b1; pwrite4 = 1'b1; penable4 = 1'b0; paddr4 = 8'h04; pwdata4 = 32'h4;
        tick();
        penable4 = 1'b1;
        ttc_int4 = 3'b100;
        tick();
        psel4 = 1'b0; penable4 = 1'b0; pwrite4 = 1'b0;
        apb_read(8'h04, rd);
        n_cmp++; if (rd !== 32'h4) begin n_err++; $display("FAIL setwin_stat: got %h expected %h", rd, 32'h4); end
        apb_read(8'h00, rd);
        n_cmp++; if (rd !== 32'h4) begin n_err++; $display("FAIL setwin_raw: got %h expected %h", rd, 32'h4); end
        tick(2);
        n_cmp++; if (irq_out4 !== 1'b1) begin n_err++; $display("FAIL setwin_irq: got %b expected 1", irq_out4); end
        apb_write(8'h04, 32'h4);
        tick(3);
        apb_read(8'h04, rd);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL held_no_reset: got %h expected 0", rd); end
        n_cmp++; if (irq_out4 !== 1'b0) begin n_err++; $display("FAIL held_irq: got %b expected 0", irq_out4); end
        ttc_int4 = 3'b000;
        tick();
    endtask

    task automatic test_mask_gate;
        apb_write(8'h08, 32'h0);
        pulse(3'b111);
        tick(3);
        apb_read(8'h04, rd);
        n_cmp++; if (rd !== 32'h7) begin n_err++; $display("FAIL mask_stat: got %h expected %h", rd, 32'h7); end
        apb_read(8'h0C, rd);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL mask_pend0: got %h expected 0", rd); end
        n_cmp++; if (irq_out4 !== 1'b0) begin n_err++; $display("FAIL mask_irq0: got %b expected 0", irq_out4); end
        apb_write(8'h08, 32'h1);
        n_cmp++; if (irq_out4 !== 1'b0) begin n_err++; $display("FAIL mask_irq_w0: got %b expected 0", irq_out4); end
        tick();
        n_cmp++; if (irq_out4 !== !COAL) begin n_err++; $display("FAIL mask_irq_w1: got %b expected %b", irq_out4, !COAL); end
        tick(3);
        n_cmp++; if (irq_out4 !== !COAL) begin n_err++; $display("FAIL mask_irq_w4: got %b expected %b", irq_out4, !COAL); end
        apb_read(8'h0C, rd);
        n_cmp++; if (rd !== 32'h1) begin n_err++; $display("FAIL mask_pend1: got %h expected %h", rd, 32'h1); end
        apb_write(8'h04, 32'h7);
        tick(2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_threshold();
        test_timeout();
        test_thr_zero_popcount();
        test_set_wins();
        test_mask_gate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
